dm_cache_ctrl: RTL and testbench

Parametrised, clocked, direct-mapped, write-through / no-write-allocate cache controller with per-line valid bits, refill from a backing memory over a valid/ready request channel, and a full-cache invalidate sequence. It sits between a single requesting master (CPU load/store port) and the next memory level. Hit and miss are reported with every response.

---
 rtl/dm_cache_pkg.sv | 29 ++
 rtl/dm_cache_array.sv | 55 +++++
 rtl/dm_cache_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_cache_pkg.sv
// Shared types and address-slicing helpers for the direct-mapped cache controller.
package dm_cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MEM_RD,
        S_MEM_WAIT,
        S_MEM_WR,
        S_RESP,
        S_FLUSH
    } state_e;

    // Widest address the slicing helper handles; callers zero-extend into it.
    localparam int ADDR_W_MAX = 64;

    function automatic int tag_width(input int addr_w, input int index_w, input int offset_w);
        return addr_w - index_w - offset_w;
    endfunction

    function automatic logic [ADDR_W_MAX-1:0] addr_field(input logic [ADDR_W_MAX-1:0] addr,
                                                         input int lsb,
                                                         input int width);
        logic [ADDR_W_MAX-1:0] mask;
        mask = (width >= ADDR_W_MAX) ? '1 : ((ADDR_W_MAX'(1) << width) - ADDR_W_MAX'(1));
        return (addr >> lsb) & mask;
    endfunction

endpackage

// File: rtl/dm_cache_array.sv
// Tag/data storage with per-line valid bits; one write port, combinational read.
module dm_cache_array
    import dm_cache_pkg::*;
#(
    parameter int INDEX_W = 8,
    parameter int TAG_W   = 22,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [DATA_W-1:0]  rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               wr_valid
);

    localparam int DEPTH = 1 << INDEX_W;

    logic [TAG_W-1:0]  tag_ram  [DEPTH];
    logic [DATA_W-1:0] data_ram [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;

    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_idx] = wr_valid;
        end
    end

    // Only the valid vector is reset; tag/data contents are meaningless while invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_ram[wr_idx]  <= wr_tag;
            data_ram[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_ram[rd_idx];
    assign rd_data  = data_ram[rd_idx];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with
// refill over a valid/ready memory channel and a sequential invalidate-all.
module dm_cache_ctrl
    import dm_cache_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [DATA_W-1:0] resp_rdata,
    input  logic              flush,
    output logic              flush_busy,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata
);

    localparam int TAG_W = tag_width(ADDR_W, INDEX_W, OFFSET_W);

    state_e              state_q, state_d;
    logic [INDEX_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic                hit_q, hit_d;
    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_hit_q, resp_hit_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                flush_busy_q, flush_busy_d;
    logic                mem_req_valid_q, mem_req_valid_d;
    logic                mem_req_we_q, mem_req_we_d;
    logic [ADDR_W-1:0]   mem_req_addr_q, mem_req_addr_d;
    logic [DATA_W-1:0]   mem_req_wdata_q, mem_req_wdata_d;

    logic                lat_we_q, lat_we_d;
    logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0]   lat_wdata_q, lat_wdata_d;

    logic                accept;
    logic [INDEX_W-1:0]  lat_idx;
    logic [TAG_W-1:0]    lat_tag;
    logic [ADDR_W-1:0]   word_addr;
    logic                lookup_hit;

    logic                rd_valid;
    logic [TAG_W-1:0]    rd_tag;
    logic [DATA_W-1:0]   rd_data;
    logic                wr_en;
    logic [INDEX_W-1:0]  wr_idx;
    logic [TAG_W-1:0]    wr_tag;
    logic [DATA_W-1:0]   wr_data;
    logic                wr_valid;

    assign lat_idx    = INDEX_W'(addr_field(ADDR_W_MAX'(lat_addr_q), OFFSET_W, INDEX_W));
    assign lat_tag    = TAG_W'(addr_field(ADDR_W_MAX'(lat_addr_q), OFFSET_W + INDEX_W, TAG_W));
    assign word_addr  = {lat_addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    assign lookup_hit = rd_valid && (rd_tag == lat_tag);

    dm_cache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (lat_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_tag   (wr_tag),
        .wr_data  (wr_data),
        .wr_valid (wr_valid)
    );

    always_comb begin
        accept          = (state_q == S_IDLE) && !flush && req_valid;
        state_d         = state_q;
        flush_cnt_d     = flush_cnt_q;
        hit_d           = hit_q;
        resp_valid_d    = 1'b0;
        resp_hit_d      = 1'b0;
        resp_rdata_d    = '0;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_we_d    = mem_req_we_q;
        mem_req_addr_d  = mem_req_addr_q;
        mem_req_wdata_d = mem_req_wdata_q;
        lat_we_d        = accept ? req_we    : lat_we_q;
        lat_addr_d      = accept ? req_addr  : lat_addr_q;
        lat_wdata_d     = accept ? req_wdata : lat_wdata_q;
        wr_en           = 1'b0;
        wr_idx          = lat_idx;
        wr_tag          = lat_tag;
        wr_data         = lat_wdata_q;
        wr_valid        = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = '0;
                end else if (accept) begin
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                hit_d = lookup_hit;
                if (!lat_we_q && lookup_hit) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_hit_d   = 1'b1;
                    resp_rdata_d = rd_data;
                end else begin
                    // Writes always go through to memory; only a hit updates the line.
                    wr_en           = lat_we_q && lookup_hit;
                    state_d         = lat_we_q ? S_MEM_WR : S_MEM_RD;
                    mem_req_valid_d = 1'b1;
                    mem_req_we_d    = lat_we_q;
                    mem_req_addr_d  = word_addr;
                    mem_req_wdata_d = lat_we_q ? lat_wdata_q : '0;
                end
            end
            S_MEM_RD: begin
                if (mem_req_ready) begin
                    state_d         = S_MEM_WAIT;
                    mem_req_valid_d = 1'b0;
                    mem_req_we_d    = 1'b0;
                    mem_req_addr_d  = '0;
                    mem_req_wdata_d = '0;
                end
            end
            S_MEM_WAIT: begin
                if (mem_resp_valid) begin
                    wr_en        = 1'b1;
                    wr_data      = mem_resp_rdata;
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = mem_resp_rdata;
                end
            end
            S_MEM_WR: begin
                if (mem_req_ready) begin
                    state_d         = S_RESP;
                    resp_valid_d    = 1'b1;
                    resp_hit_d      = hit_q;
                    mem_req_valid_d = 1'b0;
                    mem_req_we_d    = 1'b0;
                    mem_req_addr_d  = '0;
                    mem_req_wdata_d = '0;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            S_FLUSH: begin
                wr_en       = 1'b1;
                wr_idx      = flush_cnt_q;
                wr_tag      = '0;
                wr_data     = '0;
                wr_valid    = 1'b0;
                flush_cnt_d = flush_cnt_q + INDEX_W'(1);
                if (&flush_cnt_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_ready_d  = (state_d == S_IDLE);
        flush_busy_d = (state_d == S_FLUSH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            flush_cnt_q     <= '0;
            hit_q           <= 1'b0;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_hit_q      <= 1'b0;
            resp_rdata_q    <= '0;
            flush_busy_q    <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_req_we_q    <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_wdata_q <= '0;
        end else begin
            state_q         <= state_d;
            flush_cnt_q     <= flush_cnt_d;
            hit_q           <= hit_d;
            req_ready_q     <= req_ready_d;
            resp_valid_q    <= resp_valid_d;
            resp_hit_q      <= resp_hit_d;
            resp_rdata_q    <= resp_rdata_d;
            flush_busy_q    <= flush_busy_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_we_q    <= mem_req_we_d;
            mem_req_addr_q  <= mem_req_addr_d;
            mem_req_wdata_q <= mem_req_wdata_d;
        end
    end

    // Request payload is only meaningful after an accept, so it needs no reset.
    always_ff @(posedge clk) begin
        lat_we_q    <= lat_we_d;
        lat_addr_q  <= lat_addr_d;
        lat_wdata_q <= lat_wdata_d;
    end

    // Flush has priority, so a pending flush masks readiness in the same cycle.
    assign req_ready     = req_ready_q && !flush;
    assign resp_valid    = resp_valid_q;
    assign resp_hit      = resp_hit_q;
    assign resp_rdata    = resp_rdata_q;
    assign flush_busy    = flush_busy_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_we    = mem_req_we_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign mem_req_wdata = mem_req_wdata_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed self-checking bench for dm_cache_ctrl with a simple backing-memory responder.
module tb_dm_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_hit;
    logic [31:0] resp_rdata;
    logic        flush, flush_busy;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic        r_hit, r_mwe;
    logic [31:0] r_rdata, r_maddr, r_mwd;
    int          r_lat, r_nmem, r_unstable;

    always #5 clk = ~clk;

    dm_cache_ctrl #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .INDEX_W  (8),
        .OFFSET_W (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_hit       (resp_hit),
        .resp_rdata     (resp_rdata),
        .flush          (flush),
        .flush_busy     (flush_busy),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        int w = 0;
        while (!req_ready && w < 600) begin
            tick();
            w++;
        end
        chk("req_ready_wait", req_ready, 1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    // r_lat counts clock edges after the accept edge until resp_valid is seen.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] mdata, input int rdly, input int sdly);
        bit done = 1'b0;
        bit hs = 1'b0;
        int rw = 0;
        int sw = 0;
        r_hit = 1'b0; r_rdata = '0; r_lat = 0; r_nmem = 0;
        r_maddr = '0; r_mwd = '0; r_mwe = 1'b0; r_unstable = 0;
        start_req(we, addr, wd);
        for (int c = 0; c < 400 && !done; c++) begin
            tick();
            r_lat++;
            if (mem_req_ready) hs = 1'b1;
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            if (resp_valid) begin
                done    = 1'b1;
                r_hit   = resp_hit;
                r_rdata = resp_rdata;
            end else if (mem_req_valid) begin
                if (r_nmem == 0) begin
                    r_maddr = mem_req_addr;
                    r_mwd   = mem_req_wdata;
                    r_mwe   = mem_req_we;
                end else if (mem_req_addr !== r_maddr || mem_req_wdata !== r_mwd ||
                             mem_req_we !== r_mwe) begin
                    r_unstable++;
                end
                r_nmem++;
                if (rw == rdly) mem_req_ready = 1'b1;
                else rw++;
            end else if (hs && !r_mwe) begin
                if (sw == sdly) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_rdata = mdata;
                end else begin
                    sw++;
                end
            end
        end
        chk("resp_seen", done, 1);
    endtask

    task automatic run_flush(input logic with_req);
        int busy = 0;
        int bad  = 0;
        flush = 1'b1;
        if (with_req) begin
            req_valid = 1'b1;
            req_we    = 1'b0;
            req_addr  = 32'h40;
        end
        #1;
        chk("flush_masks_ready", req_ready, 0);
        tick();
        flush = 1'b0;
        chk("flush_busy_start", flush_busy, 1);
        while (flush_busy && busy < 400) begin
            if (req_ready || resp_valid || mem_req_valid) bad++;
            busy++;
            tick();
        end
        req_valid = 1'b0;
        req_addr  = '0;
        chk("flush_cycles", busy, 256);
        chk("flush_blocks_req", bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        flush = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        #22 rst = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_flush_busy", flush_busy, 0);
        chk("rst_mem_req_addr", mem_req_addr, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        tick();

        // Cold miss, then hit on the same line
        run_txn(1'b0, 32'h40, 0, 32'hCAFEBABE, 0, 3);
        chk("cold_hit", r_hit, 0);
        chk("cold_rdata", r_rdata, 32'hCAFEBABE);
        chk("cold_maddr", r_maddr, 32'h40);
        chk("cold_mwe", r_mwe, 0);
        chk("cold_lat", r_lat, 6);
        tick();
        chk("resp_single_cycle", resp_valid, 0);
        run_txn(1'b0, 32'h40, 0, 32'h0, 0, 0);
        chk("rehit_hit", r_hit, 1);
        chk("rehit_rdata", r_rdata, 32'hCAFEBABE);
        chk("rehit_lat", r_lat, 1);
        chk("rehit_nomem", r_nmem, 0);

        // Conflict on index 0
        run_txn(1'b0, 32'h0, 0, 32'h11111111, 0, 1);
        chk("c0_hit", r_hit, 0);
        run_txn(1'b0, 32'h0, 0, 32'h0, 0, 0);
        chk("c0_rehit", r_hit, 1);
        chk("c0_rdata", r_rdata, 32'h11111111);
        run_txn(1'b0, 32'h400, 0, 32'h22222222, 1, 0);
        chk("c400_hit", r_hit, 0);
        chk("c400_maddr", r_maddr, 32'h400);
        chk("c400_rdata", r_rdata, 32'h22222222);
        run_txn(1'b0, 32'h0, 0, 32'h33333333, 0, 0);
        chk("c0_evicted", r_hit, 0);
        chk("c0_refill", r_rdata, 32'h33333333);

        // Write hit and write miss
        run_txn(1'b1, 32'h40, 32'hABADDEED, 32'h0, 0, 0);
        chk("wh_hit", r_hit, 1);
        chk("wh_mwe", r_mwe, 1);
        chk("wh_maddr", r_maddr, 32'h40);
        chk("wh_mwd", r_mwd, 32'hABADDEED);
        chk("wh_rdata", r_rdata, 0);
        chk("wh_lat", r_lat, 2);
        run_txn(1'b0, 32'h42, 0, 32'h0, 0, 0);
        chk("wh_read_hit", r_hit, 1);
        chk("wh_read_data", r_rdata, 32'hABADDEED);
        chk("wh_read_nomem", r_nmem, 0);
        run_txn(1'b1, 32'h80, 32'h12345678, 32'h0, 2, 0);
        chk("wm_hit", r_hit, 0);
        chk("wm_mwe", r_mwe, 1);
        chk("wm_maddr", r_maddr, 32'h80);
        chk("wm_lat", r_lat, 4);
        run_txn(1'b0, 32'h80, 0, 32'h55555555, 0, 0);
        chk("wm_noalloc", r_hit, 0);
        chk("wm_read_data", r_rdata, 32'h55555555);

        // Memory back-pressure: request must hold steady
        run_txn(1'b0, 32'h503, 0, 32'h0BADF00D, 5, 2);
        chk("stall_maddr", r_maddr, 32'h500);
        chk("stall_stable", r_unstable, 0);
        chk("stall_nmem", r_nmem, 6);
        chk("stall_lat", r_lat, 10);
        chk("stall_rdata", r_rdata, 32'h0BADF00D);

        // Flush invalidates a valid line
        tick();
        run_flush(1'b0);
        run_txn(1'b0, 32'h40, 0, 32'h77777777, 0, 0);
        chk("flush_miss", r_hit, 0);
        chk("flush_refill", r_rdata, 32'h77777777);

        // Flush wins over a simultaneous request
        tick();
        run_flush(1'b1);
        run_txn(1'b0, 32'h40, 0, 32'h88888888, 0, 0);
        chk("flush_req_miss", r_hit, 0);

        // Reset while a memory read request is outstanding
        tick();
        start_req(1'b0, 32'h300, 0);
        tick();
        chk("mrd_valid", mem_req_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_mem_req_valid", mem_req_valid, 0);
        chk("async_mem_req_addr", mem_req_addr, 0);
        chk("async_req_ready", req_ready, 1);
        @(negedge clk) rst = 1'b0;
        tick();

        // Reset during refill wait; late response ignored
        start_req(1'b0, 32'h140, 0);
        tick();
        chk("mw_valid", mem_req_valid, 1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mw_rst_resp_valid", resp_valid, 0);
        chk("mw_rst_mem_req_valid", mem_req_valid, 0);
        chk("mw_rst_flush_busy", flush_busy, 0);
        @(negedge clk) rst = 1'b0;
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hDEADDEAD;
        tick();
        mem_resp_valid = 1'b0;
        chk("late_resp_ignored", resp_valid, 0);
        chk("late_req_ready", req_ready, 1);
        run_txn(1'b0, 32'h140, 0, 32'h99999999, 0, 0);
        chk("rst_refill_discarded", r_hit, 0);
        chk("rst_refill_data", r_rdata, 32'h99999999);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
